// File: rtl/cache_pkg.sv
// cache_pkg: FSM state encoding and default line-field widths for assoc_cache_wb
package cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, INSTALL} state_t;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int LINES_DEF = 4;
endpackage

// File: rtl/assoc_cache_wb_lru_ages.sv
// lru_ages: true-LRU age array; age 0 is most recent, age LINES-1 is the replacement candidate
module lru_ages #(
  parameter int LINES = 4,
  parameter int AGE_W = $clog2(LINES)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             touch,
  input  logic [AGE_W-1:0] touch_idx,
  output logic [AGE_W-1:0] lru_idx
);
  logic [AGE_W-1:0] age [LINES];
  logic [LINES-1:0] seen;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) for (int i = 0; i < LINES; i++) age[i] <= AGE_W'(i);
    else if (touch)
      for (int i = 0; i < LINES; i++)
        age[i] <= i == int'(touch_idx) ? '0 : age[i] < age[touch_idx] ? age[i] + 1'b1 : age[i];
  always_comb begin
    lru_idx = '0;
    seen = '0;
    for (int i = 0; i < LINES; i++) begin
      if (age[i] == AGE_W'(LINES - 1)) lru_idx = AGE_W'(i);
      seen[age[i]] = 1'b1;
    end
  end
  assert property (@(posedge clock) disable iff (!reset_n) &seen);
endmodule

// File: rtl/assoc_cache_wb.sv
// assoc_cache_wb: fully-associative write-back cache with true-LRU replacement, one word per line
module assoc_cache_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int LINES = LINES_DEF,
  parameter int AGE_W = $clog2(LINES)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_valid,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state;
  logic [ADDR_W-1:0] tag_q [LINES];
  logic [DATA_W-1:0] data_q [LINES];
  logic [LINES-1:0] valid_q, dirty_q;
  logic rq_write;
  logic [ADDR_W-1:0] rq_addr;
  logic [DATA_W-1:0] rq_wdata;
  logic [AGE_W-1:0] v_idx, hit_idx, inv_idx, lru_idx, victim, touch_idx;
  logic hit, inv, touch;
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    inv = 1'b0;
    inv_idx = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == rq_addr) begin
        hit = 1'b1;
        hit_idx = AGE_W'(i);
      end
      if (!valid_q[i]) begin
        inv = 1'b1;
        inv_idx = AGE_W'(i);
      end
    end
  end
  assign victim = inv ? inv_idx : lru_idx;
  assign touch = (state == LOOKUP && hit) || (state == FILL && mem_valid && mem_ack) || state == INSTALL;
  assign touch_idx = state == LOOKUP ? hit_idx : v_idx;
  lru_ages #(.LINES(LINES), .AGE_W(AGE_W)) u_lru (
    .clock(clock), .reset_n(reset_n), .touch(touch), .touch_idx(touch_idx), .lru_idx(lru_idx)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
        data_q[i] <= '0;
      end
      rq_write <= 1'b0;
      rq_addr <= '0;
      rq_wdata <= '0;
      v_idx <= '0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_hit <= 1'b0;
      resp_rdata <= '0;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          rq_write <= req_write;
          rq_addr <= req_addr;
          rq_wdata <= req_wdata;
          req_ready <= 1'b0;
          state <= LOOKUP;
        end
        LOOKUP: if (hit) begin
          if (rq_write) begin
            data_q[hit_idx] <= rq_wdata;
            dirty_q[hit_idx] <= 1'b1;
          end else resp_rdata <= data_q[hit_idx];
          resp_valid <= 1'b1;
          resp_hit <= 1'b1;
          req_ready <= 1'b1;
          state <= IDLE;
        end else begin
          v_idx <= victim;
          if (valid_q[victim] && dirty_q[victim]) begin
            mem_valid <= 1'b1;
            mem_write <= 1'b1;
            mem_addr <= tag_q[victim];
            mem_wdata <= data_q[victim];
            state <= WB;
          end else state <= rq_write ? INSTALL : FILL;
        end
        WB: if (mem_ack) begin
          mem_valid <= 1'b0;
          dirty_q[v_idx] <= 1'b0;
          state <= rq_write ? INSTALL : FILL;
        end
        FILL: if (!mem_valid) begin
          mem_valid <= 1'b1;
          mem_write <= 1'b0;
          mem_addr <= rq_addr;
        end else if (mem_ack) begin
          mem_valid <= 1'b0;
          tag_q[v_idx] <= rq_addr;
          data_q[v_idx] <= mem_rdata;
          valid_q[v_idx] <= 1'b1;
          dirty_q[v_idx] <= 1'b0;
          resp_rdata <= mem_rdata;
          resp_hit <= 1'b0;
          resp_valid <= 1'b1;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        INSTALL: begin
          tag_q[v_idx] <= rq_addr;
          data_q[v_idx] <= rq_wdata;
          valid_q[v_idx] <= 1'b1;
          dirty_q[v_idx] <= 1'b1;
          resp_hit <= 1'b0;
          resp_valid <= 1'b1;
          req_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_assoc_cache_wb.sv
// tb_assoc_cache_wb: directed and randomized checks of assoc_cache_wb against a line-list LRU model
module tb_assoc_cache_wb;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_ready;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic resp_valid, resp_hit;
  logic [7:0] resp_rdata;
  logic mem_valid, mem_write, mem_ack = 1'b0;
  logic [7:0] mem_addr, mem_wdata, mem_rdata = '0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  assoc_cache_wb dut (
    .clock(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  logic [7:0] ram [256];
  logic [7:0] mm [256];
  bit hold = 0, p_act = 0;
  int wcnt = 0, n_wb = 0, n_fill = 0;
  logic [7:0] wb_addr = '0, wb_data = '0, fill_addr = '0;
  logic [16:0] p_bus = '0;
  initial for (int i = 0; i < 256; i++) begin
    ram[i] = 8'(i) ^ 8'hFF;
    mm[i] = 8'(i) ^ 8'hFF;
  end
  always @(negedge clk) begin
    if (mem_valid && p_act) begin
      checks++;
      if ({mem_write, mem_addr, mem_wdata} !== p_bus) begin
        errs++;
        $display("FAIL mem_stable: got %h required %h", {mem_write, mem_addr, mem_wdata}, p_bus);
      end
    end
    if (mem_ack) mem_ack = 1'b0;
    else if (mem_valid && !hold) begin
      if (wcnt == 2) begin
        wcnt = 0;
        mem_ack = 1'b1;
        if (mem_write) begin
          ram[mem_addr] = mem_wdata;
          n_wb++;
          wb_addr = mem_addr;
          wb_data = mem_wdata;
        end else begin
          mem_rdata = ram[mem_addr];
          n_fill++;
          fill_addr = mem_addr;
        end
      end else wcnt++;
    end else wcnt = 0;
    p_act = mem_valid && !mem_ack;
    p_bus = {mem_write, mem_addr, mem_wdata};
  end
  logic [7:0] m_tag [4], m_data [4];
  bit m_v [4], m_d [4];
  int ord [$];
  logic [7:0] m_last;
  bit e_hit, e_wb;
  logic [7:0] e_rdata, e_wb_addr, e_wb_data;
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 0;
      m_d[i] = 0;
    end
    ord = {0, 1, 2, 3};
    m_last = '0;
  endtask
  task automatic model_req(input bit w, input logic [7:0] a, input logic [7:0] d);
    int h = -1, v = -1, k = 0;
    e_wb = 0;
    for (int i = 0; i < 4; i++) if (m_v[i] && m_tag[i] == a) h = i;
    e_hit = h >= 0;
    if (h < 0) begin
      for (int i = 3; i >= 0; i--) if (!m_v[i]) v = i;
      if (v < 0) v = ord[ord.size() - 1];
      if (m_v[v] && m_d[v]) begin
        e_wb = 1;
        e_wb_addr = m_tag[v];
        e_wb_data = m_data[v];
        mm[m_tag[v]] = m_data[v];
      end
      m_tag[v] = a;
      m_v[v] = 1;
      m_d[v] = w;
      m_data[v] = w ? d : mm[a];
      h = v;
    end else if (w) begin
      m_data[h] = d;
      m_d[h] = 1;
    end
    if (!w) m_last = m_data[h];
    e_rdata = m_last;
    for (int i = 0; i < ord.size(); i++) if (ord[i] == h) k = i;
    ord.delete(k);
    ord.push_front(h);
  endtask
  bit o_hit, o_mv, o_to;
  logic [7:0] o_rdata;
  int o_lat, o_wbs, o_fills, wb0, f0;
  task automatic do_reset();
    @(negedge clk);
    req_valid = 0;
    hold = 0;
    reset_n = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask
  task automatic start_req(input bit w, input logic [7:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: got req_ready=%b required 1", req_ready);
    end
    req_valid = 1;
    req_write = w;
    req_addr = a;
    req_wdata = d;
    @(posedge clk);
    #1 req_valid = 0;
    wb0 = n_wb;
    f0 = n_fill;
    o_lat = 1;
    o_mv = 0;
  endtask
  task automatic wait_resp();
    while (!resp_valid && o_lat < 300) begin
      if (mem_valid) o_mv = 1;
      @(posedge clk);
      #1 o_lat++;
    end
    o_to = !resp_valid;
    if (o_to) begin
      checks++;
      errs++;
      $display("FAIL resp_timeout: got resp_valid=%b required 1", resp_valid);
    end
    o_hit = resp_hit;
    o_rdata = resp_rdata;
    o_wbs = n_wb - wb0;
    o_fills = n_fill - f0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    reset_n = 0;
    @(posedge clk);
    #1 checks += 8;
    if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    if (resp_valid !== 1'b0) begin errs++; $display("FAIL rst_resp_valid: got %b required 0", resp_valid); end
    if (resp_hit !== 1'b0) begin errs++; $display("FAIL rst_resp_hit: got %b required 0", resp_hit); end
    if (resp_rdata !== 8'h00) begin errs++; $display("FAIL rst_resp_rdata: got %h required 00", resp_rdata); end
    if (mem_valid !== 1'b0) begin errs++; $display("FAIL rst_mem_valid: got %b required 0", mem_valid); end
    if (mem_write !== 1'b0) begin errs++; $display("FAIL rst_mem_write: got %b required 0", mem_write); end
    if (mem_addr !== 8'h00) begin errs++; $display("FAIL rst_mem_addr: got %h required 00", mem_addr); end
    if (mem_wdata !== 8'h00) begin errs++; $display("FAIL rst_mem_wdata: got %h required 00", mem_wdata); end
    @(negedge clk);
    reset_n = 1;
    model_reset();
  endtask
  task automatic test_read_fill();
    model_req(0, 8'h10, 0);
    start_req(0, 8'h10, 8'h00);
    wait_resp();
    checks += 5;
    if (o_hit !== 1'b0) begin errs++; $display("FAIL fill_hit: got %b required 0", o_hit); end
    if (o_rdata !== 8'hEF) begin errs++; $display("FAIL fill_rdata: got %h required ef", o_rdata); end
    if (o_wbs !== 0) begin errs++; $display("FAIL fill_no_wb: got %0d required 0", o_wbs); end
    if (o_fills !== 1) begin errs++; $display("FAIL fill_count: got %0d required 1", o_fills); end
    if (fill_addr !== 8'h10) begin errs++; $display("FAIL fill_addr: got %h required 10", fill_addr); end
    model_req(0, 8'h10, 0);
    start_req(0, 8'h10, 8'h00);
    wait_resp();
    checks += 4;
    if (o_hit !== 1'b1) begin errs++; $display("FAIL rehit_hit: got %b required 1", o_hit); end
    if (o_rdata !== 8'hEF) begin errs++; $display("FAIL rehit_rdata: got %h required ef", o_rdata); end
    if (o_lat !== 2) begin errs++; $display("FAIL rehit_latency: got %0d required 2", o_lat); end
    if (o_mv !== 1'b0) begin errs++; $display("FAIL rehit_mem: got %b required 0", o_mv); end
  endtask
  task automatic test_write_install();
    model_req(1, 8'h20, 8'h5A);
    start_req(1, 8'h20, 8'h5A);
    wait_resp();
    checks += 3;
    if (o_hit !== 1'b0) begin errs++; $display("FAIL install_hit: got %b required 0", o_hit); end
    if (o_mv !== 1'b0) begin errs++; $display("FAIL install_mem: got %b required 0", o_mv); end
    if (o_rdata !== 8'hEF) begin errs++; $display("FAIL install_rdata_hold: got %h required ef", o_rdata); end
    model_req(0, 8'h20, 0);
    start_req(0, 8'h20, 8'h00);
    wait_resp();
    checks += 2;
    if (o_hit !== 1'b1) begin errs++; $display("FAIL install_rehit: got %b required 1", o_hit); end
    if (o_rdata !== 8'h5A) begin errs++; $display("FAIL install_rdata: got %h required 5a", o_rdata); end
  endtask
  task automatic test_lru_victim();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      model_req(0, 8'(i), 0);
      start_req(0, 8'(i), 8'h00);
      wait_resp();
    end
    model_req(0, 8'h01, 0);
    start_req(0, 8'h01, 8'h00);
    wait_resp();
    checks++;
    if (o_hit !== 1'b1) begin errs++; $display("FAIL lru_touch_hit: got %b required 1", o_hit); end
    model_req(0, 8'h05, 0);
    start_req(0, 8'h05, 8'h00);
    wait_resp();
    checks += 3;
    if (o_wbs !== 0) begin errs++; $display("FAIL lru_clean_no_wb: got %0d required 0", o_wbs); end
    if (fill_addr !== 8'h05) begin errs++; $display("FAIL lru_fill_addr: got %h required 05", fill_addr); end
    if (o_rdata !== 8'hFA) begin errs++; $display("FAIL lru_fill_rdata: got %h required fa", o_rdata); end
    model_req(0, 8'h01, 0);
    start_req(0, 8'h01, 8'h00);
    wait_resp();
    checks++;
    if (o_hit !== 1'b1) begin errs++; $display("FAIL lru_rehit: got %b required 1", o_hit); end
  endtask
  task automatic test_writeback();
    bit hv [4];
    for (int i = 1; i <= 4; i++) begin
      model_req(1, 8'(i), 8'hA0 + 8'(i));
      start_req(1, 8'(i), 8'hA0 + 8'(i));
      wait_resp();
      hv[i - 1] = o_hit;
    end
    checks += 2;
    if (hv[0] !== 1'b1) begin errs++; $display("FAIL wb_write01_hit: got %b required 1", hv[0]); end
    if (hv[1] !== 1'b0) begin errs++; $display("FAIL wb_write02_evicted: got %b required 0", hv[1]); end
    model_req(0, 8'h09, 0);
    start_req(0, 8'h09, 8'h00);
    wait_resp();
    checks += 5;
    if (o_wbs !== 1) begin errs++; $display("FAIL wb_count: got %0d required 1", o_wbs); end
    if (wb_addr !== 8'h01) begin errs++; $display("FAIL wb_addr: got %h required 01", wb_addr); end
    if (wb_data !== 8'hA1) begin errs++; $display("FAIL wb_data: got %h required a1", wb_data); end
    if (fill_addr !== 8'h09) begin errs++; $display("FAIL wb_fill_addr: got %h required 09", fill_addr); end
    if (o_rdata !== 8'hF6) begin errs++; $display("FAIL wb_fill_rdata: got %h required f6", o_rdata); end
  endtask
  task automatic test_hold_ack();
    int n = 0;
    do_reset();
    hold = 1;
    model_req(0, 8'h40, 0);
    start_req(0, 8'h40, 8'h00);
    while (!mem_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req_valid = i[0];
      req_write = 1;
      req_addr = 8'h41;
      req_wdata = 8'h77;
      @(posedge clk);
      #1 checks += 4;
      if (mem_valid !== 1'b1) begin errs++; $display("FAIL hold_mem_valid: got %b required 1", mem_valid); end
      if (mem_addr !== 8'h40) begin errs++; $display("FAIL hold_mem_addr: got %h required 40", mem_addr); end
      if (mem_write !== 1'b0) begin errs++; $display("FAIL hold_mem_write: got %b required 0", mem_write); end
      if (req_ready !== 1'b0) begin errs++; $display("FAIL hold_req_ready: got %b required 0", req_ready); end
    end
    req_valid = 0;
    hold = 0;
    wait_resp();
    checks += 2;
    if (o_hit !== 1'b0) begin errs++; $display("FAIL hold_hit: got %b required 0", o_hit); end
    if (o_rdata !== 8'hBF) begin errs++; $display("FAIL hold_rdata: got %h required bf", o_rdata); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errs++;
        $display("FAIL hold_ignored: got resp_valid=%b req_ready=%b required 0 1", resp_valid, req_ready);
      end
    end
  endtask
  task automatic test_reset_mid_wb();
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      model_req(1, 8'h30 + 8'(i), 8'h11 + 8'(i));
      start_req(1, 8'h30 + 8'(i), 8'h11 + 8'(i));
      wait_resp();
    end
    start_req(0, 8'h34, 8'h00);
    while (!mem_valid && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    checks += 2;
    if (mem_write !== 1'b1) begin errs++; $display("FAIL midwb_write: got %b required 1", mem_write); end
    if (mem_addr !== 8'h30) begin errs++; $display("FAIL midwb_addr: got %h required 30", mem_addr); end
    @(negedge clk);
    reset_n = 0;
    #1 checks += 2;
    if (mem_valid !== 1'b0) begin errs++; $display("FAIL midwb_mem_valid: got %b required 0", mem_valid); end
    if (req_ready !== 1'b1) begin errs++; $display("FAIL midwb_req_ready: got %b required 1", req_ready); end
    @(negedge clk);
    reset_n = 1;
    model_reset();
    model_req(0, 8'h30, 0);
    start_req(0, 8'h30, 8'h00);
    wait_resp();
    checks += 3;
    if (o_hit !== 1'b0) begin errs++; $display("FAIL midwb_lost_hit: got %b required 0", o_hit); end
    if (o_rdata !== 8'hCF) begin errs++; $display("FAIL midwb_lost_rdata: got %h required cf", o_rdata); end
    if (o_wbs !== 0) begin errs++; $display("FAIL midwb_no_wb: got %0d required 0", o_wbs); end
  endtask
  task automatic test_random();
    bit w;
    logic [7:0] a, d;
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      w = $urandom_range(0, 9) < 4;
      a = $urandom_range(0, 15) == 0 ? 8'($urandom) : 8'($urandom_range(0, 9));
      d = 8'($urandom);
      model_req(w, a, d);
      start_req(w, a, d);
      wait_resp();
      checks += 3;
      if (o_hit !== e_hit) begin errs++; $display("FAIL rnd_hit #%0d addr %h: got %b required %b", k, a, o_hit, e_hit); end
      if (o_rdata !== e_rdata) begin errs++; $display("FAIL rnd_rdata #%0d addr %h: got %h required %h", k, a, o_rdata, e_rdata); end
      if (o_wbs !== int'(e_wb)) begin errs++; $display("FAIL rnd_wb_count #%0d: got %0d required %0d", k, o_wbs, e_wb); end
      if (e_wb) begin
        checks += 2;
        if (wb_addr !== e_wb_addr) begin errs++; $display("FAIL rnd_wb_addr #%0d: got %h required %h", k, wb_addr, e_wb_addr); end
        if (wb_data !== e_wb_data) begin errs++; $display("FAIL rnd_wb_data #%0d: got %h required %h", k, wb_data, e_wb_data); end
      end
      if (e_hit) begin
        checks++;
        if (o_lat !== 2) begin errs++; $display("FAIL rnd_hit_latency #%0d: got %0d required 2", k, o_lat); end
      end
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_read_fill();
    test_write_install();
    test_lru_victim();
    test_writeback();
    test_hold_ack();
    test_reset_mid_wb();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
